// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data memory.
// Optional feature: define DMEM_ARB_BOUNDS_CHECK_EN to flag and suppress out-of-range accesses.
module dmem_arbiter #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int DATA_W = 32;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || DEPTH < 1) begin : g_param_check
        $error("dmem_arbiter: WAIT_CYCLES must be 1..15 and DEPTH positive");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t              state;
    logic                last;
    logic                win;
    logic [3:0]          cnt;

    logic                pick;
    logic                sel_we;
    logic                sel_oob;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        pick      = (req0 && req1) ? ~last : req1;
        sel_we    = pick ? we1    : we0;
        sel_addr  = pick ? addr1  : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        sel_oob   = (sel_addr >= DATA_W'(DEPTH));
`else
        sel_oob   = 1'b0;
`endif
    end

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    logic lat_oob;
`else
    assign err = 1'b0;
`endif

    // mem_* registers double as the latched request, so requester changes cannot reach the memory.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            cnt       <= 4'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
            lat_oob   <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win       <= pick;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_read  <= ~sel_we && ~sel_oob;
                        mem_write <= sel_we && ~sel_oob;
                        cnt       <= 4'(WAIT_CYCLES - 1);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
                        lat_oob   <= sel_oob;
`endif
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // mem_read is only set for in-range reads, so it gates the capture.
                        if (mem_read) begin
                            if (win) rdata1 <= mem_rdata;
                            else     rdata0 <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        done0     <= ~win;
                        done1     <= win;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
                        err       <= lat_oob;
`endif
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
                    err   <= 1'b0;
`endif
                    last  <= win;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, transaction-level reference model.
// Bounds-check scenarios are compiled in when DMEM_ARB_BOUNDS_CHECK_EN is defined.
module tb_dmem_arbiter;

    localparam int DEPTH = 64;
    localparam int W     = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1, err, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clock = ~clock;

    dmem_arbiter #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 5) ? 32'h1234_5678 : {b, 8'hC3, ~b, 8'h5A};
    endfunction

    // Behavioural single-port RAM: loads known contents in reset, writes on posedge, reads on negedge.
    logic [31:0] bmem [0:DEPTH-1];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) bmem[i] <= init_word(i);
        end else if (mem_write) begin
            bmem[mem_addr[5:0]] <= mem_wdata;
        end
    end
    always @(negedge clock) mem_rdata <= bmem[mem_addr[5:0]];

    int          asserts = 0;
    int          fails   = 0;
    logic [31:0] ref_mem [0:DEPTH-1];
    bit          mlast;
    logic [31:0] exp_rd0, exp_rd1;
    bit          tb_idle;

    function automatic logic [6:0] ctrl();
        return {gnt0, gnt1, done0, done1, mem_read, mem_write, err};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        mlast   = 1'b1;
        exp_rd0 = '0;
        exp_rd1 = '0;
        tb_idle = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        asserts++;
        if (ctrl() !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0000000", ctrl());
        end
        asserts++;
        if ({mem_addr, mem_wdata, rdata0, rdata1} !== 128'b0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h expected all 0",
                     mem_addr, mem_wdata, rdata0, rdata1);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic rand_op(input bit p);
        logic [31:0] a;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        a = 32'($urandom_range(0, DEPTH + 7));
`else
        a = 32'($urandom_range(0, DEPTH - 1));
`endif
        if (p) begin we1 = 1'($urandom); addr1 = a; wdata1 = $urandom; end
        else   begin we0 = 1'($urandom); addr0 = a; wdata0 = $urandom; end
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(negedge clock);
            asserts++;
            if (ctrl() !== 7'b0) begin
                fails++;
                $display("FAIL idle_ctrl: got %b expected 0000000", ctrl());
            end
        end
        tb_idle = 1'b1;
    endtask

    // One complete access: winner chosen from the requests currently driven, checked every cycle.
    task automatic xfer(input bit drop_early);
        bit          p, we, oob;
        logic [31:0] a, wd;
        logic [6:0]  exp_c;
        if (req0 && req1) p = (mlast == 1'b1) ? 1'b0 : 1'b1;
        else              p = req1 ? 1'b1 : 1'b0;
        we = p ? we1 : we0;
        a  = p ? addr1 : addr0;
        wd = p ? wdata1 : wdata0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        oob = (a >= 32'(DEPTH));
`else
        oob = 1'b0;
`endif
        if (!tb_idle) begin
            @(posedge clock);
            @(negedge clock);
            asserts++;
            if (ctrl() !== 7'b0) begin
                fails++;
                $display("FAIL idle_between: got %b expected 0000000", ctrl());
            end
        end
        @(posedge clock);
        for (int i = 1; i <= W; i++) begin
            @(negedge clock);
            if (drop_early && i == 1) begin
                if (p) req1 = 1'b0; else req0 = 1'b0;
            end
            exp_c = {~p, p, 2'b00, ~we && ~oob, we && ~oob, 1'b0};
            asserts++;
            if (ctrl() !== exp_c) begin
                fails++;
                $display("FAIL access_ctrl cyc%0d port%0d: got %b expected %b", i, p, ctrl(), exp_c);
            end
            asserts++;
            if (mem_addr !== a) begin
                fails++;
                $display("FAIL access_addr: got %h expected %h", mem_addr, a);
            end
            if (we && !oob) begin
                asserts++;
                if (mem_wdata !== wd) begin
                    fails++;
                    $display("FAIL access_wdata: got %h expected %h", mem_wdata, wd);
                end
            end
        end
        @(negedge clock);
        if (!oob) begin
            if (we)     ref_mem[a[5:0]] = wd;
            else if (p) exp_rd1 = ref_mem[a[5:0]];
            else        exp_rd0 = ref_mem[a[5:0]];
        end
        exp_c = {~p, p, ~p, p, 2'b00, oob};
        asserts++;
        if (ctrl() !== exp_c) begin
            fails++;
            $display("FAIL done_ctrl port%0d: got %b expected %b", p, ctrl(), exp_c);
        end
        asserts++;
        if ({rdata0, rdata1} !== {exp_rd0, exp_rd1}) begin
            fails++;
            $display("FAIL done_rdata: got rd0=%h rd1=%h expected rd0=%h rd1=%h",
                     rdata0, rdata1, exp_rd0, exp_rd1);
        end
        mlast   = p;
        tb_idle = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        idle_gap(2);
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5; wdata0 = 32'h0;
        xfer(1'b0);
        asserts++;
        if (rdata0 !== 32'h1234_5678) begin
            fails++;
            $display("FAIL single_read: got %h expected 12345678", rdata0);
        end
        req0 = 1'b0;
        idle_gap(2);
    endtask

    task automatic test_write_read();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd10; wdata1 = 32'hDEAD_BEEF;
        xfer(1'b0);
        we1 = 1'b0;
        xfer(1'b0);
        asserts++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL write_read: got %h expected deadbeef", rdata1);
        end
        req1 = 1'b0;
        idle_gap(1);
    endtask

    task automatic test_contention();
        req0 = 1'b1; req1 = 1'b1;
        rand_op(1'b0);
        rand_op(1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0);
            rand_op(mlast);
        end
        req0 = 1'b0; req1 = 1'b0;
        idle_gap(1);
    endtask

    task automatic test_withdraw();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
        xfer(1'b1);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd21;
        xfer(1'b0);
        req0 = 1'b0;
        idle_gap(1);
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
        @(posedge clock);
        @(negedge clock);
        req0 = 1'b0;
        do_reset();
        idle_gap(2);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
        xfer(1'b0);
        req0 = 1'b0;
        idle_gap(1);
    endtask

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    task automatic test_bounds();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd64;
        xfer(1'b0);
        addr0 = 32'd63;
        xfer(1'b0);
        we0 = 1'b1; addr0 = 32'd64; wdata0 = 32'hFFFF_0000;
        xfer(1'b0);
        req0 = 1'b0;
        idle_gap(1);
    endtask
`endif

    task automatic test_random();
        int r;
        for (int n = 0; n < 40; n++) begin
            if (!req0 && !req1) begin
                idle_gap($urandom_range(1, 2));
                r = $urandom_range(1, 3);
                if (r[0]) begin req0 = 1'b1; rand_op(1'b0); end
                if (r[1]) begin req1 = 1'b1; rand_op(1'b1); end
            end
            xfer(($urandom % 4) == 0);
            if ($urandom % 2) begin
                if (mlast) req1 = 1'b1; else req0 = 1'b1;
                rand_op(mlast);
            end else begin
                if (mlast) req1 = 1'b0; else req0 = 1'b0;
            end
            if (!mlast && !req1 && ($urandom % 2)) begin req1 = 1'b1; rand_op(1'b1); end
            if (mlast && !req0 && ($urandom % 2))  begin req0 = 1'b1; rand_op(1'b0); end
        end
        req0 = 1'b0; req1 = 1'b0;
        idle_gap(1);
    endtask

    initial begin
        #2;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_withdraw();
        test_reset_mid();
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        test_bounds();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory in the MIPS datapath. It shares one memory port between requester 0 (load/store unit) and requester 1 (debug/DMA loader). It accepts word-addressed read and write requests, grants one requester at a time with round-robin fairness, and drives the memory's `address`/`read`/`write`/`writeData` for a fixed number of wait cycles. It then registers `readData` and returns it with a one-cycle `done` pulse.

## Interface
- `DEPTH`, 64: memory depth in words; valid word addresses are 0..DEPTH-1.
- `WAIT_CYCLES`, 1: cycles the memory strobes are held per access; legal range 1..15.

- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: access request, level; held until `done` for that port.
- `we0` / `we1` in 1: 1 = write, 0 = read; stable while `req` is high.
- `addr0` / `addr1` in 32: word address; stable while `req` is high.
- `wdata0` / `wdata1` in 32: write data; stable while `req` is high.
- `gnt0` / `gnt1` out 1: high while the port owns the memory (ACCESS and DONE states).
- `done0` / `done1` out 1: one-cycle pulse when the access completes.
- `rdata0` / `rdata1` out 32: read result; valid with `done`; holds until that port's next read completes.
- `err` out 1: bounds error flag, valid with `done`. Only when `DMEM_ARB_BOUNDS_CHECK_EN` is defined; otherwise tied 0.
- `mem_addr` out 32: to memory `address`.
- `mem_read` / `mem_write` out 1: to memory `read` / `write`.
- `mem_wdata` out 32: to memory `writeData`.
- `mem_rdata` in 32: from memory `readData`.

## Operation
- FSM states:
  - IDLE: no grant. If any `req` is high, latch the winner, capture its `we`/`addr`/`wdata` into internal registers, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
  - ACCESS: drive the mem_* outputs from the latched registers. Decrement the counter each cycle. When it reaches 0, register `mem_rdata` into the winner's `rdata` (reads only) and go to DONE.
  - DONE: pulse the winner's `done`. Update `last` to the winner. Go to IDLE unconditionally.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the port not equal to `last` wins.
  - `last` resets to 1, so port 0 wins the first tie.
- The memory inputs are driven only from latched registers. Requester changes after grant do not affect the access in flight.
- `req` dropped during ACCESS: the access still completes and `done` still pulses.
- `rdata` of the non-winning port is never modified.
- Write access:
  - `mem_write` is high in every ACCESS cycle; `mem_read` stays 0.
  - `rdata` is unchanged.
  - `done` still pulses.

## Timing
- Reset values (asynchronous; outputs and state valid immediately after `reset` falls):
  - State IDLE, `last`=1.
  - All `gnt`, `done`, `mem_read`, `mem_write` and `err` are 0.
  - `mem_addr`, `mem_wdata`, `rdata0` and `rdata1` are 0.
- Request sampled at rising edge k, state IDLE:
  - ACCESS occupies cycles k+1..k+WAIT_CYCLES.
  - `done` is high for cycle k+WAIT_CYCLES+1.
  - IDLE resumes at edge k+WAIT_CYCLES+2.
- Latency from accept to `done` is WAIT_CYCLES+1 cycles. One access per WAIT_CYCLES+2 cycles.
- Requesters see `done` and must drop or change `req` in the same cycle. The arbiter re-samples at the next IDLE edge, so a still-high `req` starts a new access.
- `mem_rdata` is sampled at the rising edge that ends the last ACCESS cycle. The memory must present data by then; its negedge update satisfies this.
- `reset` asserted mid-access: immediate return to IDLE with all reset values. No `done` pulse. A write in progress may or may not have been committed.

## Configuration
- `DMEM_ARB_BOUNDS_CHECK_EN` defined:
  - At accept, `addr >= DEPTH` is flagged.
  - A flagged access still goes through ACCESS with `mem_read` and `mem_write` held 0, so the memory is not touched.
  - `rdata` is unchanged; `err`=1 during DONE.
- Not defined: no check and `err` is tied to 0. `mem_addr` passes the full 32-bit address.

## Test plan
- Single read: memory word 5 = 0x1234_5678; `req0`=1, `we0`=0, `addr0`=5 at edge k (WAIT_CYCLES=1) -> `mem_read`=1 in cycle k+1, `done0`=1 in cycle k+2, `rdata0`=0x1234_5678, `gnt1`=0 throughout.
- Write then read: port 1 writes 0xDEAD_BEEF to address 10, then port 1 reads address 10 -> `mem_write` high for exactly WAIT_CYCLES cycles, then `rdata1`=0xDEAD_BEEF with `done1`.
- Contention: `req0`=`req1`=1 held continuously from reset -> grants alternate 0,1,0,1; `done` pulses every WAIT_CYCLES+2 cycles; `rdata0` is never touched by port 1 accesses.
- Request withdrawal: `req1` dropped one cycle after grant -> `done1` still pulses at k+WAIT_CYCLES+1; next arbitration grants port 0.
- Reset mid-access: `reset`=0 during ACCESS -> all outputs 0 immediately, no `done`; after release, a read of address 3 completes normally.
- Bounds (macro defined): read of address 64 -> `mem_read`/`mem_write` stay 0, `err`=1 with `done0`, `rdata0` keeps its prior value; address 63 -> `err`=0.
